// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for both sides of the dual-clock FIFO. This covers the default
// widths, the pointer type and the Gray/binary conversions.
package cdc_fifo_pkg;
  localparam int CDC_DATA_W = 8;
  localparam int CDC_ADDR_W = 3;
  // The conversion helpers work on this fixed width. Callers zero-extend on the
  // way in and truncate on the way out, so any pointer up to this width can use them.
  localparam int PTR_MAX_W  = 16;

  typedef logic [CDC_ADDR_W:0] ptr_t;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros in the extended Gray value map to leading zeros in binary,
  // so narrower pointers convert correctly.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/ptr_sync_2ff.sv
// Multi-bit flop chain that brings a Gray pointer into the local clock domain.
// It is safe only because the Gray source changes at most one bit per step.
module ptr_sync_2ff #(
  parameter int W   = 4,
  parameter int STG = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [STG-1:0][W-1:0] r_stg;

  // Shift the incoming pointer through STG stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stg <= '0;
    end else begin
      r_stg[0] <= i_d;
      for (int i = 1; i < STG; i++) r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_q = r_stg[STG-1];
endmodule

// File: rtl/source_write_control.sv
// Write-side controller of the async FIFO. It accepts writes, drives the storage
// write port and publishes a Gray write pointer. It also computes full,
// almost_full and overflow from the synchronised read pointer. Every output is a flop.
module source_write_control
  import cdc_fifo_pkg::*;
#(
  parameter int DATA_W   = CDC_DATA_W,
  parameter int ADDR_W   = CDC_ADDR_W,
  parameter int AFULL_TH = 6,
  parameter int SYNC_STG = 2
) (
  input  logic              clk_s,
  input  logic              rst_n,
  input  logic              write_signal,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W:0]   read_ptr_gray,
  output logic [ADDR_W:0]   write_ptr_gray,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              write_permission,
  output logic              full,
  output logic              almost_full,
  output logic              overflow
);
  localparam int PW = ADDR_W + 1;

  logic [PW-1:0]     r_wbin, r_wptr_gray;
  logic              r_we, r_perm, r_full, r_afull, r_ovf;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [PW-1:0] w_rptr_sync, w_rbin_sync, w_wbin_next, w_gray_next, w_occ;
  logic          w_accept, w_full_next, w_afull_next;

  ptr_sync_2ff #(.W(PW), .STG(SYNC_STG)) u_rptr_sync (
    .i_clk   (clk_s),
    .i_rst_n (rst_n),
    .i_d     (read_ptr_gray),
    .o_q     (w_rptr_sync)
  );

  // Accept decision, next pointer and the flag values for the next cycle.
  // Full compares against the pre-advance synchronised read pointer. This is
  // pessimistic, but it never overwrites unread data.
  always_comb begin
    w_accept     = write_signal & ~r_full;
    w_wbin_next  = r_wbin + PW'(w_accept);
    w_gray_next  = PW'(bin2gray(PTR_MAX_W'(w_wbin_next)));
    w_rbin_sync  = PW'(gray2bin(PTR_MAX_W'(w_rptr_sync)));
    w_occ        = w_wbin_next - w_rbin_sync;
    w_full_next  = (w_gray_next ==
                    {~w_rptr_sync[ADDR_W:ADDR_W-1], w_rptr_sync[ADDR_W-2:0]});
    w_afull_next = (w_occ >= PW'(AFULL_TH));
  end

  // Pointer registers; the Gray copy is the only value crossing to the read side.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin      <= '0;
      r_wptr_gray <= '0;
    end else begin
      r_wbin      <= w_wbin_next;
      r_wptr_gray <= w_gray_next;
    end
  end

  // Storage write port. Address and data hold when nothing is accepted.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_perm  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we   <= w_accept;
      r_perm <= w_accept;
      if (w_accept) begin
        r_addr  <= r_wbin[ADDR_W-1:0];
        r_wdata <= din;
      end
    end
  end

  // Status flags. Overflow is sticky until reset.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
      r_ovf   <= r_ovf | (write_signal & r_full);
    end
  end

  assign write_ptr_gray   = r_wptr_gray;
  assign mem_we           = r_we;
  assign mem_addr         = r_addr;
  assign mem_wdata        = r_wdata;
  assign write_permission = r_perm;
  assign full             = r_full;
  assign almost_full      = r_afull;
  assign overflow         = r_ovf;
endmodule

// File: tb/tb_source_write_control.sv
// Bench for source_write_control. It combines a table-driven fill/overflow
// sequence, hand-written multi-cycle corner cases, and a randomised run
// against a count-based reference model.
module tb_source_write_control;
  localparam int STG = 2;

  logic       clk_s = 1'b0, rst_n = 1'b0, write_signal = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] read_ptr_gray = '0;
  logic [3:0] write_ptr_gray;
  logic       mem_we, write_permission, full, almost_full, overflow;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata;

  int n_cmp = 0, n_err = 0;

  always #5 clk_s = ~clk_s;

  source_write_control #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .SYNC_STG(STG)) dut (
    .clk_s(clk_s), .rst_n(rst_n), .write_signal(write_signal), .din(din),
    .read_ptr_gray(read_ptr_gray), .write_ptr_gray(write_ptr_gray), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .write_permission(write_permission),
    .full(full), .almost_full(almost_full), .overflow(overflow)
  );

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       we, perm, fu, af, ov;
    logic [2:0] addr;
    logic [7:0] data;
    logic [3:0] wg;
  } vec_t;

  function automatic logic [3:0] g4(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mkv(input logic wr, input logic [7:0] d, input logic we,
                               input logic [2:0] addr, input logic [7:0] data,
                               input logic [3:0] wg, input logic fu, input logic af,
                               input logic ov);
    vec_t v;
    v.wr = wr; v.d = d; v.we = we; v.perm = we; v.addr = addr; v.data = data;
    v.wg = wg; v.fu = fu; v.af = af; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic we, input logic perm,
                         input logic [2:0] addr, input logic [7:0] data,
                         input logic [3:0] wg, input logic fu, input logic af,
                         input logic ov);
    chk({nm, ".mem_we"},   int'(mem_we),           int'(we));
    chk({nm, ".perm"},     int'(write_permission), int'(perm));
    chk({nm, ".addr"},     int'(mem_addr),         int'(addr));
    chk({nm, ".wdata"},    int'(mem_wdata),        int'(data));
    chk({nm, ".wptr"},     int'(write_ptr_gray),   int'(wg));
    chk({nm, ".full"},     int'(full),             int'(fu));
    chk({nm, ".afull"},    int'(almost_full),      int'(af));
    chk({nm, ".overflow"}, int'(overflow),         int'(ov));
  endtask

  // Drive inputs on the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic wr, input logic [7:0] d, input int rc);
    @(negedge clk_s);
    write_signal  = wr;
    din           = d;
    read_ptr_gray = g4(rc);
    @(posedge clk_s);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_s);
    rst_n = 1'b0; write_signal = 1'b0; din = '0; read_ptr_gray = '0;
    @(posedge clk_s);
    @(negedge clk_s);
    rst_n = 1'b1;
  endtask

  vec_t       tbl[10];
  logic [3:0] prev_g;
  // reference-model state: counts of accepted writes and of reads presented
  int         wc, rc, rs, h[$];
  logic       mf, maf, mov, acc, wr;
  logic [2:0] ma;
  logic [7:0] md, d;

  initial begin
    // Fill to full with the reader parked at 0, then write once more while full.
    for (int i = 0; i < 8; i++)
      tbl[i] = mkv(1'b1, 8'(8'h10 + i), 1'b1, 3'(i), 8'(8'h10 + i), g4(i + 1),
                   (i == 7), (i >= 5), 1'b0);
    tbl[8] = mkv(1'b1, 8'h55, 1'b0, 3'd7, 8'h17, 4'b1100, 1'b1, 1'b1, 1'b1);
    tbl[9] = mkv(1'b0, 8'h66, 1'b0, 3'd7, 8'h17, 4'b1100, 1'b1, 1'b1, 1'b1);

    // reset state
    @(posedge clk_s); #1;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_s); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].wr, tbl[i].d, 0);
      chk_out($sformatf("tbl%0d", i), tbl[i].we, tbl[i].perm, tbl[i].addr, tbl[i].data,
              tbl[i].wg, tbl[i].fu, tbl[i].af, tbl[i].ov);
    end

    // Drain release: full drops SYNC_STG+1 edges after the read pointer moves.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1);
      chk($sformatf("drain.full%0d", i), int'(full), (i < 2) ? 1 : 0);
    end
    step(1'b1, 8'h99, 1);
    chk("drain.we",   int'(mem_we),         1);
    chk("drain.addr", int'(mem_addr),       0);
    chk("drain.wptr", int'(write_ptr_gray), int'(4'b1101));
    chk("drain.full", int'(full),           1);

    // Reset asserted mid-write: everything clears without waiting for an edge.
    @(negedge clk_s); write_signal = 1'b1; din = 8'hAA;
    @(posedge clk_s); #3;
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_s); write_signal = 1'b0;
    @(negedge clk_s); rst_n = 1'b1;

    // almost_full rises on the 6th accept and clears after the read advances to 2.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(i), 0);
      chk($sformatf("af.w%0d", i), int'(almost_full), (i >= 5) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 2);
      chk($sformatf("af.r%0d", i), int'(almost_full), (i < 2) ? 1 : 0);
      chk($sformatf("af.f%0d", i), int'(full), 0);
    end

    // Wrap: 20 writes with the reader two behind the writer.
    do_reset();
    prev_g = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i), (i >= 2) ? i - 2 : 0);
      chk($sformatf("wrap.addr%0d", i), int'(mem_addr), i % 8);
      chk($sformatf("wrap.we%0d", i), int'(mem_we), 1);
      chk($sformatf("wrap.wptr%0d", i), int'(write_ptr_gray), int'(g4(i + 1)));
      chk($sformatf("wrap.onebit%0d", i), $countones(write_ptr_gray ^ prev_g), 1);
      chk($sformatf("wrap.full%0d", i), int'(full), 0);
      prev_g = write_ptr_gray;
    end

    // Randomised run. The model is occupancy = accepted writes minus the read
    // count the synchroniser presented SYNC_STG edges earlier.
    do_reset();
    wc = 0; rc = 0; mf = 0; maf = 0; mov = 0; ma = '0; md = '0;
    h.delete();
    for (int i = 0; i < STG; i++) h.push_back(0);
    for (int k = 0; k < 400; k++) begin
      wr = ($urandom_range(0, 9) < (((k / 100) % 2 == 0) ? 7 : 3));
      d  = 8'($urandom);
      if (rc < wc && $urandom_range(0, 9) < (((k / 100) % 2 == 0) ? 3 : 8)) rc++;
      rs  = h[0];
      acc = wr && !mf;
      if (wr && mf) mov = 1'b1;
      if (acc) begin
        ma = 3'(wc);
        md = d;
        wc++;
      end
      mf  = ((wc - rs) == 8);
      maf = ((wc - rs) >= 6);
      h.push_back(rc);
      void'(h.pop_front());
      step(wr, d, rc);
      chk_out($sformatf("rnd%0d", k), acc, acc, ma, md, g4(wc), mf, maf, mov);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
